fast_square_sweep_ctrl: RTL
===========================

Name: fast_square_sweep_ctrl

Overview:
- Sequencer for the fast-square baseband slicer.
- Steps the LO through a programmed number of frequency points. At each point it:
  - waits a settle interval,
  - emits one restart marker word,
  - gates record for a fixed number of 16-bit sliced words, issuing one data_out_strobe per completed word.
- Sits between the serial control registers and the fast_square_bb / RX FIFO path.

Parameters:
- STEP_W, 8, width of step count and step index.
- CNT_W, 16, width of settle and words-per-step counters.
- WORD_BITS, 16, sliced bits per output word (samples per data_out_strobe).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  level; low aborts any sweep and holds IDLE
- start  in  1  one-cycle pulse; starts a sweep from IDLE
- continuous  in  1  1 = wrap to step 0 after the last step instead of finishing
- num_steps  in  STEP_W  frequency points per sweep; 0 treated as 1
- settle_len  in  CNT_W  sample_strobes discarded after each freq_step
- words_per_step  in  CNT_W  data words recorded per point; 0 treated as 1
- sample_strobe  in  1  one baseband sample presented to the slicer this cycle
- fifo_full  in  1  RX FIFO full flag
- freq_step  out  1  one-cycle pulse: advance LO to next point
- record  out  1  high while the slicer output is captured
- restart_data  out  1  one-cycle pulse selecting the 16'h8000 marker word
- data_out_strobe  out  1  one-cycle pulse: write current slicer word
- step_index  out  STEP_W  current point, 0-based
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at normal sweep completion
- overrun  out  1  sticky: a strobe was issued while fifo_full

Behaviour:
- All outputs are registered.
- During reset (low): state = IDLE, all outputs 0, all counters 0.
- Configuration latching:
  - num_steps, settle_len, words_per_step and continuous are latched on the accepted start.
  - Changes mid-sweep have no effect.
- FSM states: IDLE, STEP, SETTLE, MARK, RECORD, NEXT, DONE.
- IDLE:
  - start & enable -> STEP.
  - On entry: step_index = 0, overrun cleared.
  - start while not IDLE is ignored.
- STEP:
  - freq_step = 1 for exactly this cycle.
  - settle_cnt = 0 -> SETTLE.
- SETTLE:
  - Each sample_strobe increments settle_cnt.
  - Exit to MARK once settle_cnt == settle_len; settle_len = 0 exits on the first SETTLE cycle.
  - record = 0 throughout.
- MARK (one cycle):
  - record = 1, restart_data = 1, data_out_strobe = 1.
  - Clears bit_cnt and word_cnt -> RECORD.
- RECORD:
  - record = 1.
  - Each sample_strobe increments bit_cnt mod WORD_BITS.
  - The strobe that wraps bit_cnt from WORD_BITS-1 to 0 causes data_out_strobe on the next cycle and increments word_cnt.
  - When word_cnt reaches words_per_step, that final data_out_strobe is issued and the FSM moves to NEXT in the same transition; record drops with the transition.
- NEXT (one cycle):
  - If step_index == num_steps-1:
    - continuous -> step_index = 0, go to STEP;
    - otherwise -> DONE.
  - Else step_index + 1 -> STEP.
- DONE: done = 1 for one cycle -> IDLE; busy falls with IDLE.
- enable low in any non-IDLE state:
  - next state IDLE, outputs cleared next cycle, no done pulse, step_index holds.
  - overrun retained until the next start.
- Overrun: any cycle with data_out_strobe & fifo_full sets overrun. Strobes are still issued; no backpressure stalls.
- Markers: one per point. Total data_out_strobes per point = words_per_step + 1.
- Simultaneous sample_strobe with state exit:
  - A strobe in the last SETTLE cycle counts only toward settle.
  - No strobe is counted during STEP, MARK or NEXT.
- Asynchronous reset mid-sweep: immediate return to IDLE, all outputs 0 without waiting for a clock edge.

Test Plan:
- Reset/idle: reset low with start pulsed -> all outputs 0, busy 0; release reset with no start -> busy stays 0.
- Basic sweep: num_steps=3, settle_len=4, words_per_step=2, sample_strobe every cycle, continuous=0 ->
  - 3 freq_step pulses;
  - per point: 4 settle strobes, 1 restart_data pulse, then 2 data_out_strobes 16 cycles apart;
  - step_index 0,1,2; done after the last word;
  - 9 data_out_strobes total.
- Zero edge cases: num_steps=0, settle_len=0, words_per_step=0 -> one freq_step, MARK on the cycle after SETTLE entry, exactly one data word, done.
- Continuous wrap: num_steps=2, continuous=1 -> step_index sequence 0,1,0,1…, no done pulse; enable low -> busy 0 next cycle, no done.
- Overrun: fifo_full=1 during the second word of point 0 -> overrun=1 and stays 1 through sweep end; a new start clears it.
- Sparse strobes and ignored restart: sample_strobe every 3rd cycle, words_per_step=1 -> data_out_strobe one cycle after the 16th strobe; start pulsed mid-sweep -> ignored, step_index unaffected.

Source files
------------

// File: rtl/fast_square_sweep_ctrl.sv
// Sweep sequencer for the fast-square baseband slicer: steps the LO through
// N points, settles, emits a restart marker, then gates record for a fixed word count.
module fast_square_sweep_ctrl #(
    parameter int STEP_W    = 8,
    parameter int CNT_W     = 16,
    parameter int WORD_BITS = 16
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic              continuous_i,
    input  logic [STEP_W-1:0] num_steps_i,
    input  logic [CNT_W-1:0]  settle_len_i,
    input  logic [CNT_W-1:0]  words_per_step_i,
    input  logic              sample_strobe_i,
    input  logic              fifo_full_i,
    output logic              freq_step_o,
    output logic              record_o,
    output logic              restart_data_o,
    output logic              data_out_strobe_o,
    output logic [STEP_W-1:0] step_index_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o
);

    localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WORD_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_SETTLE, S_MARK, S_RECORD, S_NEXT, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [STEP_W-1:0]  num_steps_q, num_steps_d;
    logic [CNT_W-1:0]   settle_len_q, settle_len_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic               continuous_q, continuous_d;
    logic               word_strobe_d;
    logic               overrun_q, overrun_d;
    logic               freq_step_q, record_q, restart_q, data_out_strobe_q, busy_q, done_q;
    logic               settle_hit;

    // The strobe that completes the settle count ends SETTLE in the same cycle.
    assign settle_hit = (settle_cnt_q == settle_len_q) ||
                        (sample_strobe_i && (settle_cnt_q + CNT_ONE == settle_len_q));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        step_d        = step_q;
        num_steps_d   = num_steps_q;
        settle_len_d  = settle_len_q;
        words_d       = words_q;
        continuous_d  = continuous_q;
        word_strobe_d = 1'b0;
        overrun_d     = overrun_q | (data_out_strobe_q & fifo_full_i);

        unique case (state_q)
            S_IDLE: begin
                if (start_i && enable_i) begin
                    state_d      = S_STEP;
                    step_d       = '0;
                    overrun_d    = 1'b0;
                    num_steps_d  = (num_steps_i == '0) ? STEP_ONE : num_steps_i;
                    settle_len_d = settle_len_i;
                    words_d      = (words_per_step_i == '0) ? CNT_ONE : words_per_step_i;
                    continuous_d = continuous_i;
                end
            end
            S_STEP: begin
                settle_cnt_d = '0;
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_hit) begin
                    state_d = S_MARK;
                end else if (sample_strobe_i) begin
                    settle_cnt_d = settle_cnt_q + CNT_ONE;
                end
            end
            S_MARK: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                state_d    = S_RECORD;
            end
            S_RECORD: begin
                if (sample_strobe_i) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d     = '0;
                        word_cnt_d    = word_cnt_q + CNT_ONE;
                        word_strobe_d = 1'b1;
                        if (word_cnt_q + CNT_ONE == words_q) begin
                            state_d = S_NEXT;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end
            S_NEXT: begin
                if (step_q == num_steps_q - STEP_ONE) begin
                    if (continuous_q) begin
                        step_d  = '0;
                        state_d = S_STEP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    step_d  = step_q + STEP_ONE;
                    state_d = S_STEP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything: back to IDLE silently, index frozen.
        if (!enable_i && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            step_d        = step_q;
            word_strobe_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q           <= S_IDLE;
            settle_cnt_q      <= '0;
            bit_cnt_q         <= '0;
            word_cnt_q        <= '0;
            step_q            <= '0;
            num_steps_q       <= '0;
            settle_len_q      <= '0;
            words_q           <= '0;
            continuous_q      <= 1'b0;
            overrun_q         <= 1'b0;
            freq_step_q       <= 1'b0;
            record_q          <= 1'b0;
            restart_q         <= 1'b0;
            data_out_strobe_q <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            settle_cnt_q      <= settle_cnt_d;
            bit_cnt_q         <= bit_cnt_d;
            word_cnt_q        <= word_cnt_d;
            step_q            <= step_d;
            num_steps_q       <= num_steps_d;
            settle_len_q      <= settle_len_d;
            words_q           <= words_d;
            continuous_q      <= continuous_d;
            overrun_q         <= overrun_d;
            freq_step_q       <= (state_d == S_STEP);
            record_q          <= (state_d == S_MARK) || (state_d == S_RECORD);
            restart_q         <= (state_d == S_MARK);
            data_out_strobe_q <= (state_d == S_MARK) || word_strobe_d;
            busy_q            <= (state_d != S_IDLE);
            done_q            <= (state_d == S_DONE);
        end
    end

    assign freq_step_o       = freq_step_q;
    assign record_o          = record_q;
    assign restart_data_o    = restart_q;
    assign data_out_strobe_o = data_out_strobe_q;
    assign step_index_o      = step_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign overrun_o         = overrun_q;

endmodule
